// File: rtl/gte_mac_pkg.sv
// Shared constants and types for the GTE multiply-accumulate pipeline.
// IR clamp limits, the fixed-point shift amount and the per-lane flag bundle.
package gte_mac_pkg;

    localparam int IR_MAX   = 32'sd32767;
    localparam int IR_MIN   = -32'sd32768;
    localparam int SF_SHIFT = 32'sd12;

    typedef struct packed {
        logic mac_pos;
        logic mac_neg;
        logic ir_sat;
    } lane_flags_t;

    // Lower IR bound: lm pins negative results to zero.
    function automatic int ir_floor(input logic lm);
        int lo;
        if (lm) begin
            lo = 32'sd0;
        end else begin
            lo = IR_MIN;
        end
        return lo;
    endfunction

endpackage

// File: rtl/gte_mac_lane.sv
// One MAC lane: S1 product, S2 wrapping accumulate, S3 shift + IR clamp.
// Overflow/saturation flags exist only when GTE_MAC_FLAGS_EN is defined.
module gte_mac_lane
    import gte_mac_pkg::*;
#(
    parameter int MUL_W = 16,
    parameter int ACC_W = 44
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               take,
    input  logic               take_first,
    input  logic [MUL_W-1:0]   a,
    input  logic [MUL_W-1:0]   b,
    input  logic [ACC_W-1:0]   init,
    input  logic               s1_valid,
    input  logic               s1_first,
    input  logic               s2_done,
    input  logic               op_sf,
    input  logic               op_lm,
    output logic [31:0]        mac,
    output logic [15:0]        ir,
    output lane_flags_t        flags
);

    localparam int PW = 2 * MUL_W;
    localparam logic signed [ACC_W-1:0] IR_HI = ACC_W'(IR_MAX);

    logic signed [PW-1:0]    a_ext_s;
    logic signed [PW-1:0]    b_ext_s;
    logic signed [PW-1:0]    prod_r;
    logic signed [ACC_W-1:0] init_r;
    logic signed [ACC_W-1:0] acc_r;
    logic signed [ACC_W-1:0] base_s;
    logic signed [ACC_W-1:0] add_s;
    logic signed [ACC_W-1:0] shifted_s;
    logic signed [ACC_W-1:0] ir_lo_s;
    logic        [15:0]      ir_s;
    logic        [31:0]      mac_r;
    logic        [15:0]      ir_r;
`ifdef GTE_MAC_FLAGS_EN
    logic signed [ACC_W:0]   sum_s;
    logic                    ovf_pos_s;
    logic                    ovf_neg_s;
    logic                    sat_s;
    logic                    pos_r;
    logic                    neg_r;
    lane_flags_t             flags_r;
`else
    logic signed [ACC_W-1:0] sum_s;
`endif

    // Operand sign extension and S2 sum; the extra sum bit exposes wrap direction.
    always_comb begin
        a_ext_s = PW'($signed(a));
        b_ext_s = PW'($signed(b));
        base_s  = s1_first ? init_r : acc_r;
        add_s   = ACC_W'(prod_r);
`ifdef GTE_MAC_FLAGS_EN
        sum_s     = {base_s[ACC_W-1], base_s} + {add_s[ACC_W-1], add_s};
        ovf_pos_s = (sum_s[ACC_W:ACC_W-1] == 2'b01);
        ovf_neg_s = (sum_s[ACC_W:ACC_W-1] == 2'b10);
`else
        sum_s     = base_s + add_s;
`endif
    end

    // S3 shift and clamp to the IR window.
    always_comb begin
        shifted_s = op_sf ? (acc_r >>> SF_SHIFT) : acc_r;
        ir_lo_s   = ACC_W'(ir_floor(op_lm));
        if (shifted_s > IR_HI) begin
            ir_s = IR_HI[15:0];
        end else if (shifted_s < ir_lo_s) begin
            ir_s = ir_lo_s[15:0];
        end else begin
            ir_s = shifted_s[15:0];
        end
`ifdef GTE_MAC_FLAGS_EN
        sat_s = (shifted_s > IR_HI) || (shifted_s < ir_lo_s);
`endif
    end

    // S1 product register; the seed is captured with the first term only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_r <= '0;
            init_r <= '0;
        end else if (en && take) begin
            prod_r <= a_ext_s * b_ext_s;
            if (take_first) begin
                init_r <= init;
            end
        end
    end

    // S2 accumulator, stored wrapped to ACC_W bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= '0;
        end else if (en && s1_valid) begin
            acc_r <= sum_s[ACC_W-1:0];
        end
    end

    // S3 result register, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mac_r <= '0;
            ir_r  <= '0;
        end else if (en && s2_done) begin
            mac_r <= shifted_s[31:0];
            ir_r  <= ir_s;
        end
    end

`ifdef GTE_MAC_FLAGS_EN
    // Sticky overflow flags restart with each operation's first term.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_r <= 1'b0;
            neg_r <= 1'b0;
        end else if (en && s1_valid) begin
            pos_r <= ovf_pos_s | (pos_r & ~s1_first);
            neg_r <= ovf_neg_s | (neg_r & ~s1_first);
        end
    end

    // Flags are latched alongside the result they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_r <= '0;
        end else if (en && s2_done) begin
            flags_r.mac_pos <= pos_r;
            flags_r.mac_neg <= neg_r;
            flags_r.ir_sat  <= sat_s;
        end
    end

    assign flags = flags_r;
`else
    assign flags = '0;
`endif

    assign mac = mac_r;
    assign ir  = ir_r;

endmodule

// File: rtl/gte_mac_pipe.sv
// Three-stage multi-lane MAC pipeline with term/result handshakes and full-pipe stall.
// Build option GTE_MAC_FLAGS_EN enables the per-lane overflow/saturation flags.
module gte_mac_pipe
    import gte_mac_pkg::*;
#(
    parameter int LANES = 3,
    parameter int MUL_W = 16,
    parameter int ACC_W = 44
) (
    input  logic                   i_clk,
    input  logic                   i_nRst,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic                   i_first,
    input  logic                   i_last,
    input  logic [LANES*MUL_W-1:0] i_a,
    input  logic [LANES*MUL_W-1:0] i_b,
    input  logic [LANES*ACC_W-1:0] i_init,
    input  logic                   i_sf,
    input  logic                   i_lm,
    output logic                   o_resValid,
    input  logic                   i_resReady,
    output logic [LANES*32-1:0]    o_mac,
    output logic [LANES*16-1:0]    o_ir,
    output logic [LANES-1:0]       o_macPos,
    output logic [LANES-1:0]       o_macNeg,
    output logic [LANES-1:0]       o_irSat
);

    logic        en_s;
    logic        accept_s;
    logic        s2_done_s;
    logic        s1_valid_r;
    logic        s1_first_r;
    logic        s1_last_r;
    logic        s1_sf_r;
    logic        s1_lm_r;
    logic        s2_valid_r;
    logic        s2_last_r;
    logic        s2_sf_r;
    logic        s2_lm_r;
    logic        res_valid_r;
    lane_flags_t lane_flags_s [LANES];

    // A held result freezes every stage, so nothing new may enter either.
    always_comb begin
        en_s      = !(res_valid_r && !i_resReady);
        accept_s  = i_valid && en_s;
        s2_done_s = s2_valid_r && s2_last_r;
    end

    // Stage valids and markers; sf/lm ride with the operation's first term.
    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            s1_valid_r  <= 1'b0;
            s1_first_r  <= 1'b0;
            s1_last_r   <= 1'b0;
            s1_sf_r     <= 1'b0;
            s1_lm_r     <= 1'b0;
            s2_valid_r  <= 1'b0;
            s2_last_r   <= 1'b0;
            s2_sf_r     <= 1'b0;
            s2_lm_r     <= 1'b0;
            res_valid_r <= 1'b0;
        end else if (en_s) begin
            s1_valid_r <= accept_s;
            s1_first_r <= accept_s && i_first;
            s1_last_r  <= accept_s && i_last;
            if (accept_s && i_first) begin
                s1_sf_r <= i_sf;
                s1_lm_r <= i_lm;
            end
            s2_valid_r <= s1_valid_r;
            s2_last_r  <= s1_valid_r && s1_last_r;
            if (s1_valid_r && s1_first_r) begin
                s2_sf_r <= s1_sf_r;
                s2_lm_r <= s1_lm_r;
            end
            res_valid_r <= s2_done_s;
        end
    end

    assign o_ready    = en_s;
    assign o_resValid = res_valid_r;

    for (genvar n = 0; n < LANES; n++) begin : g_lane
        gte_mac_lane #(
            .MUL_W (MUL_W),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk        (i_clk),
            .rst_n      (i_nRst),
            .en         (en_s),
            .take       (accept_s),
            .take_first (i_first),
            .a          (i_a[n*MUL_W +: MUL_W]),
            .b          (i_b[n*MUL_W +: MUL_W]),
            .init       (i_init[n*ACC_W +: ACC_W]),
            .s1_valid   (s1_valid_r),
            .s1_first   (s1_first_r),
            .s2_done    (s2_done_s),
            .op_sf      (s2_sf_r),
            .op_lm      (s2_lm_r),
            .mac        (o_mac[n*32 +: 32]),
            .ir         (o_ir[n*16 +: 16]),
            .flags      (lane_flags_s[n])
        );
        assign o_macPos[n] = lane_flags_s[n].mac_pos;
        assign o_macNeg[n] = lane_flags_s[n].mac_neg;
        assign o_irSat[n]  = lane_flags_s[n].ir_sat;
    end

endmodule

// File: tb/tb_gte_mac_pipe.sv
// Self-checking bench for gte_mac_pipe: directed cases plus random operations
// checked against an integer-arithmetic model of the dot-product rules.
module tb_gte_mac_pipe;

    localparam int LANES = 3;
    localparam int MUL_W = 16;
    localparam int ACC_W = 44;
`ifdef GTE_MAC_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif
    localparam longint HALF = longint'(1) << (ACC_W - 1);
    localparam longint FULL = longint'(1) << ACC_W;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   i_valid, o_ready, i_first, i_last, i_sf, i_lm;
    logic [LANES*MUL_W-1:0] i_a, i_b;
    logic [LANES*ACC_W-1:0] i_init;
    logic                   o_resValid, i_resReady;
    logic [LANES*32-1:0]    o_mac;
    logic [LANES*16-1:0]    o_ir;
    logic [LANES-1:0]       o_macPos, o_macNeg, o_irSat;

    always #5 clk = ~clk;

    gte_mac_pipe #(.LANES(LANES), .MUL_W(MUL_W), .ACC_W(ACC_W)) dut (
        .i_clk(clk), .i_nRst(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_first(i_first), .i_last(i_last), .i_a(i_a), .i_b(i_b), .i_init(i_init),
        .i_sf(i_sf), .i_lm(i_lm), .o_resValid(o_resValid), .i_resReady(i_resReady),
        .o_mac(o_mac), .o_ir(o_ir), .o_macPos(o_macPos), .o_macNeg(o_macNeg), .o_irSat(o_irSat)
    );

    typedef struct {
        logic [LANES*MUL_W-1:0] a;
        logic [LANES*MUL_W-1:0] b;
        logic [LANES*ACC_W-1:0] init;
        logic first, last, sf, lm;
    } term_t;

    typedef struct {
        logic [LANES*32-1:0] mac;
        logic [LANES*16-1:0] ir;
        logic [LANES-1:0]    pos, neg, sat;
    } res_t;

    term_t terms[$];
    res_t  exp_q[$];
    res_t  got_q[$];
    int    checks = 0;
    int    errors = 0;
    int    timeouts;
    bit    hold_changed, hold_ready_seen;

    function automatic term_t mk(input longint a, input longint b, input longint init,
                                 input logic first, input logic last, input logic sf, input logic lm);
        term_t t;
        for (int n = 0; n < LANES; n++) begin
            t.a[n*MUL_W +: MUL_W]    = a[MUL_W-1:0];
            t.b[n*MUL_W +: MUL_W]    = b[MUL_W-1:0];
            t.init[n*ACC_W +: ACC_W] = init[ACC_W-1:0];
        end
        t.first = first; t.last = last; t.sf = sf; t.lm = lm;
        return t;
    endfunction

    function automatic res_t sample_out();
        res_t r;
        r.mac = o_mac; r.ir = o_ir; r.pos = o_macPos; r.neg = o_macNeg; r.sat = o_irSat;
        return r;
    endfunction

    function automatic bit res_eq(input res_t x, input res_t y);
        return (x.mac === y.mac) && (x.ir === y.ir) && (x.pos === y.pos) &&
               (x.neg === y.neg) && (x.sat === y.sat);
    endfunction

    function automatic longint floor_div4096(input longint v);
        if (v >= 0) return v / 64'sd4096;
        else return -((-v + 64'sd4095) / 64'sd4096);
    endfunction

    // Reference: exact integer dot product, wrapped to ACC_W after each add.
    function automatic void model_ops();
        longint acc [LANES];
        bit     pos [LANES];
        bit     neg [LANES];
        bit     open = 1'b0, sf = 1'b0, lm = 1'b0;
        logic signed [MUL_W-1:0] av, bv;
        logic signed [ACC_W-1:0] iv;
        longint base, sum, v, lo, irv;
        res_t   r;
        exp_q.delete();
        for (int n = 0; n < LANES; n++) begin acc[n] = 0; pos[n] = 0; neg[n] = 0; end
        foreach (terms[k]) begin
            if (terms[k].first) begin open = 1'b1; sf = terms[k].sf; lm = terms[k].lm; end
            for (int n = 0; n < LANES; n++) begin
                av = terms[k].a[n*MUL_W +: MUL_W];
                bv = terms[k].b[n*MUL_W +: MUL_W];
                iv = terms[k].init[n*ACC_W +: ACC_W];
                if (terms[k].first) begin base = longint'(iv); pos[n] = 0; neg[n] = 0; end
                else base = acc[n];
                sum = base + longint'(av) * longint'(bv);
                if (sum > HALF - 1) pos[n] = 1;
                if (sum < -HALF) neg[n] = 1;
                acc[n] = ((sum + HALF) % FULL + FULL) % FULL - HALF;
            end
            if (terms[k].last && open) begin
                for (int n = 0; n < LANES; n++) begin
                    v   = sf ? floor_div4096(acc[n]) : acc[n];
                    lo  = lm ? 0 : -32768;
                    irv = (v > 32767) ? 32767 : ((v < lo) ? lo : v);
                    r.mac[n*32 +: 32] = v[31:0];
                    r.ir[n*16 +: 16]  = irv[15:0];
                    r.pos[n] = FLAGS_ON & pos[n];
                    r.neg[n] = FLAGS_ON & neg[n];
                    r.sat[n] = FLAGS_ON & (irv != v);
                end
                exp_q.push_back(r);
                open = 1'b0;
            end
        end
    endfunction

    function automatic term_t rand_term(input logic first, input logic last, input logic sf, input logic lm);
        term_t  t;
        longint iv;
        int     mode;
        for (int n = 0; n < LANES; n++) begin
            mode = $urandom_range(0, 5);
            t.a[n*MUL_W +: MUL_W] = (mode == 0) ? 16'h7FFF : ((mode == 1) ? 16'h8000 : 16'($urandom));
            t.b[n*MUL_W +: MUL_W] = (mode == 0) ? 16'h7FFF : 16'($urandom);
            case ($urandom_range(0, 3))
                0:       iv = (HALF - 1) - longint'($urandom_range(0, 1 << 30));
                1:       iv = -HALF + longint'($urandom_range(0, 1 << 30));
                2:       iv = longint'($signed(32'($urandom))) <<< 8;
                default: iv = longint'($signed(32'($urandom_range(0, 1 << 20)))) - 64'sd524288;
            endcase
            t.init[n*ACC_W +: ACC_W] = iv[ACC_W-1:0];
        end
        t.first = first; t.last = last; t.sf = sf; t.lm = lm;
        return t;
    endfunction

    function automatic void gen_ops(input int n_ops);
        int  len;
        bit  sf, lm;
        terms.delete();
        for (int op = 0; op < n_ops; op++) begin
            sf = 1'($urandom); lm = 1'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                len = $urandom_range(1, 2);
                for (int k = 0; k < len; k++) terms.push_back(rand_term(k == 0, 1'b0, sf, lm));
            end
            len = $urandom_range(1, 4);
            for (int k = 0; k < len; k++) terms.push_back(rand_term(k == 0, k == len - 1, sf, lm));
        end
    endfunction

    // Drives the term queue and collects results; optional output hold after the first result.
    task automatic run_stream(input int gap_pct, input int ready_pct, input int hold_cycles, input int n_expect);
        got_q.delete();
        timeouts = 0; hold_changed = 1'b0; hold_ready_seen = 1'b0;
        fork
            begin : drv
                int idx = 0;
                int guard = 0;
                while (idx < terms.size() && guard < 4000) begin
                    @(negedge clk);
                    if ($urandom_range(0, 99) < gap_pct) begin
                        i_valid = 1'b0;
                    end else begin
                        i_valid = 1'b1; i_a = terms[idx].a; i_b = terms[idx].b; i_init = terms[idx].init;
                        i_first = terms[idx].first; i_last = terms[idx].last;
                        i_sf = terms[idx].sf; i_lm = terms[idx].lm;
                    end
                    #1;
                    if (i_valid && o_ready) idx++;
                    guard++;
                end
                @(negedge clk);
                i_valid = 1'b0; i_first = 1'b0; i_last = 1'b0;
                if (idx < terms.size()) timeouts++;
            end
            begin : col
                int   guard = 0;
                int   hold_left = hold_cycles;
                bit   held = 1'b0;
                res_t hv;
                while (got_q.size() < n_expect && guard < 4000) begin
                    @(negedge clk);
                    if (hold_left > 0 && o_resValid) begin
                        i_resReady = 1'b0;
                        #1;
                        if (!held) begin hv = sample_out(); held = 1'b1; end
                        else if (!res_eq(hv, sample_out())) hold_changed = 1'b1;
                        if (o_ready) hold_ready_seen = 1'b1;
                        hold_left--;
                    end else begin
                        i_resReady = ($urandom_range(0, 99) < ready_pct);
                        #1;
                        if (o_resValid && i_resReady) got_q.push_back(sample_out());
                    end
                    guard++;
                end
                if (got_q.size() < n_expect) timeouts++;
                @(negedge clk);
                i_resReady = 1'b1;
            end
        join
    endtask

    task automatic test_reset();
        checks++; if (o_resValid !== 1'b0) begin errors++; $display("FAIL reset_resValid: got %b want 0", o_resValid); end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", o_ready); end
        checks++; if (o_mac !== '0) begin errors++; $display("FAIL reset_mac: got %h want 0", o_mac); end
        checks++; if (o_ir !== '0) begin errors++; $display("FAIL reset_ir: got %h want 0", o_ir); end
        checks++; if ({o_macPos, o_macNeg, o_irSat} !== '0) begin errors++; $display("FAIL reset_flags: got %b want 0", {o_macPos, o_macNeg, o_irSat}); end
    endtask

    task automatic test_latency();
        term_t t;
        int    vseen [4];
        t = mk(64'h1000, 64'h1000, 64'h0, 1'b1, 1'b1, 1'b1, 1'b0);
        i_resReady = 1'b1;
        @(negedge clk);
        i_valid = 1'b1; i_a = t.a; i_b = t.b; i_init = t.init;
        i_first = 1'b1; i_last = 1'b1; i_sf = 1'b1; i_lm = 1'b0;
        @(posedge clk);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            i_valid = 1'b0;
            vseen[c] = o_resValid;
        end
        checks++; if ({vseen[1][0], vseen[2][0], vseen[3][0]} !== 3'b001) begin errors++; $display("FAIL latency: valid after edges 1..3 got %b want 001", {vseen[1][0], vseen[2][0], vseen[3][0]}); end
        checks++; if (o_mac !== {LANES{32'h0000_1000}}) begin errors++; $display("FAIL latency_mac: got %h want %h", o_mac, {LANES{32'h0000_1000}}); end
        checks++; if (o_ir !== {LANES{16'h1000}}) begin errors++; $display("FAIL latency_ir: got %h want %h", o_ir, {LANES{16'h1000}}); end
        checks++; if ({o_macPos, o_macNeg, o_irSat} !== '0) begin errors++; $display("FAIL latency_flags: got %b want 0", {o_macPos, o_macNeg, o_irSat}); end
        @(negedge clk);
        checks++; if (o_resValid !== 1'b0) begin errors++; $display("FAIL latency_drop: resValid got %b want 0", o_resValid); end
    endtask

    task automatic test_directed();
        terms.delete();
        terms.push_back(mk(64'h7FFF, 64'h7FFF, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0));
        terms.push_back(mk(64'h7FFF, 64'h7FFF, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0));
        terms.push_back(mk(64'h7FFF, 64'h7FFF, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0));
        terms.push_back(mk(64'sd1, 64'sd1, HALF - 1, 1'b1, 1'b1, 1'b0, 1'b0));
        terms.push_back(mk(-64'sd1, 64'sd1, -HALF, 1'b1, 1'b1, 1'b0, 1'b0));
        terms.push_back(mk(-64'sh2000, 64'h1000, 64'h0, 1'b1, 1'b1, 1'b1, 1'b1));
        terms.push_back(mk(-64'sh2000, 64'h1000, 64'h0, 1'b1, 1'b1, 1'b1, 1'b0));
        run_stream(0, 100, 0, 5);
        checks++; if (got_q.size() !== 5 || timeouts !== 0) begin errors++; $display("FAIL directed_count: got %0d results (timeouts %0d) want 5", got_q.size(), timeouts); end
        if (got_q.size() == 5) begin
            checks++; if (got_q[0].mac !== {LANES{32'hBFFD_0003}} || got_q[0].ir !== {LANES{16'h7FFF}} || got_q[0].sat !== {LANES{FLAGS_ON}})
                begin errors++; $display("FAIL three_term: mac=%h ir=%h sat=%b want mac=%h ir=%h sat=%b", got_q[0].mac, got_q[0].ir, got_q[0].sat, {LANES{32'hBFFD_0003}}, {LANES{16'h7FFF}}, {LANES{FLAGS_ON}}); end
            checks++; if (got_q[1].mac !== {LANES{32'h0}} || got_q[1].pos !== {LANES{FLAGS_ON}} || got_q[1].neg !== '0)
                begin errors++; $display("FAIL wrap_pos: mac=%h pos=%b neg=%b want mac=0 pos=%b neg=0", got_q[1].mac, got_q[1].pos, got_q[1].neg, {LANES{FLAGS_ON}}); end
            checks++; if (got_q[2].mac !== {LANES{32'hFFFF_FFFF}} || got_q[2].neg !== {LANES{FLAGS_ON}} || got_q[2].pos !== '0)
                begin errors++; $display("FAIL wrap_neg: mac=%h pos=%b neg=%b want mac=ffffffff pos=0 neg=%b", got_q[2].mac, got_q[2].pos, got_q[2].neg, {LANES{FLAGS_ON}}); end
            checks++; if (got_q[3].ir !== '0 || got_q[3].sat !== {LANES{FLAGS_ON}})
                begin errors++; $display("FAIL lm_clamp: ir=%h sat=%b want ir=0 sat=%b", got_q[3].ir, got_q[3].sat, {LANES{FLAGS_ON}}); end
            checks++; if (got_q[4].ir !== {LANES{16'hE000}} || got_q[4].mac !== {LANES{32'hFFFF_E000}} || got_q[4].sat !== '0)
                begin errors++; $display("FAIL no_lm: ir=%h mac=%h sat=%b want ir=%h mac=%h sat=0", got_q[4].ir, got_q[4].mac, got_q[4].sat, {LANES{16'hE000}}, {LANES{32'hFFFF_E000}}); end
        end
    endtask

    task automatic test_abort();
        terms.delete();
        terms.push_back(mk(64'sd5, 64'sd5, 64'sd100, 1'b1, 1'b0, 1'b0, 1'b0));
        terms.push_back(mk(64'sd7, 64'sd7, 64'sd0, 1'b0, 1'b0, 1'b0, 1'b0));
        terms.push_back(mk(64'sd2, 64'sd3, 64'sd0, 1'b1, 1'b1, 1'b0, 1'b0));
        run_stream(0, 100, 0, 1);
        checks++; if (got_q.size() !== 1 || timeouts !== 0) begin errors++; $display("FAIL abort_count: got %0d want 1", got_q.size()); end
        else begin
            checks++; if (got_q[0].mac !== {LANES{32'd6}}) begin errors++; $display("FAIL abort_value: got %h want %h", got_q[0].mac, {LANES{32'd6}}); end
        end
    endtask

    task automatic check_against_model(input string name);
        checks++;
        if (got_q.size() !== exp_q.size() || timeouts !== 0) begin
            errors++; $display("FAIL %s_count: got %0d results (timeouts %0d) want %0d", name, got_q.size(), timeouts, exp_q.size());
        end
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            checks++;
            if (!res_eq(got_q[k], exp_q[k])) begin
                errors++;
                $display("FAIL %s[%0d]: got mac=%h ir=%h p/n/s=%b/%b/%b want mac=%h ir=%h p/n/s=%b/%b/%b", name, k,
                         got_q[k].mac, got_q[k].ir, got_q[k].pos, got_q[k].neg, got_q[k].sat,
                         exp_q[k].mac, exp_q[k].ir, exp_q[k].pos, exp_q[k].neg, exp_q[k].sat);
            end
        end
    endtask

    task automatic test_random();
        gen_ops(60);
        model_ops();
        run_stream(25, 70, 0, exp_q.size());
        check_against_model("random");
    endtask

    task automatic test_back_to_back();
        gen_ops(30);
        model_ops();
        run_stream(0, 100, 0, exp_q.size());
        check_against_model("back_to_back");
    endtask

    task automatic test_backpressure();
        gen_ops(10);
        model_ops();
        run_stream(0, 100, 10, exp_q.size());
        checks++; if (hold_changed !== 1'b0) begin errors++; $display("FAIL hold_stable: output changed=%b want 0", hold_changed); end
        checks++; if (hold_ready_seen !== 1'b0) begin errors++; $display("FAIL hold_ready: ready seen high=%b want 0", hold_ready_seen); end
        check_against_model("backpressure");
    endtask

    task automatic test_midop_reset();
        bit stale = 1'b0;
        terms.delete();
        terms.push_back(mk(64'h100, 64'h100, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0));
        run_stream(0, 100, 0, 1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            i_valid = 1'b1; i_a = {LANES{16'h0123}}; i_b = {LANES{16'h0456}}; i_init = '0;
            i_first = (k == 0); i_last = 1'b0; i_sf = 1'b0; i_lm = 1'b0;
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++; if (o_resValid !== 1'b0 || o_mac !== '0 || o_ir !== '0 || {o_macPos, o_macNeg, o_irSat} !== '0)
            begin errors++; $display("FAIL midop_reset: valid=%b mac=%h ir=%h want all 0", o_resValid, o_mac, o_ir); end
        i_valid = 1'b0; i_first = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL midop_ready: got %b want 1", o_ready); end
        i_resReady = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (o_resValid) stale = 1'b1;
        end
        checks++; if (stale !== 1'b0) begin errors++; $display("FAIL midop_stale: stale result seen=%b want 0", stale); end
    endtask

    initial begin
        rst_n = 1'b0; i_valid = 1'b0; i_first = 1'b0; i_last = 1'b0; i_sf = 1'b0; i_lm = 1'b0;
        i_a = '0; i_b = '0; i_init = '0; i_resReady = 1'b1;
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_latency();
        test_directed();
        test_abort();
        test_back_to_back();
        test_random();
        test_backpressure();
        test_midop_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gte_mac_pipe.md
GTE_MAC_PIPE -- requirements
Module: gte_mac_pipe

Interface
REQ-001 Parameter LANES, 3, number of parallel MAC lanes (1..4).
REQ-002 Parameter MUL_W, 16, signed width of each multiplier operand.
REQ-003 Parameter ACC_W, 44, signed accumulator wrap width per lane.
REQ-004 i_clk  in  1  single clock; all state on rising edge.
REQ-005 i_nRst  in  1  reset, asynchronous, active-low.
REQ-006 i_valid / o_ready  in / out  1 / 1  term handshake; a term is accepted when both are high.
REQ-007 i_first, i_last  in  1, 1  term marks the start / end of a dot product (both high = single-term operation).
REQ-008 i_a, i_b  in  LANES*MUL_W each  signed operands, lane n at bits [n*MUL_W +: MUL_W].
REQ-009 i_init  in  LANES*ACC_W  signed accumulator seed, sampled with the i_first term.
REQ-010 i_sf, i_lm  in  1, 1  shift-by-12 select and IR lower-clamp-to-zero, sampled with the i_first term.
REQ-011 o_resValid / i_resReady  out / in  1 / 1  result handshake.
REQ-012 o_mac  out  LANES*32  shifted accumulator, low 32 bits per lane.
REQ-013 o_ir  out  LANES*16  saturated IR value per lane.
REQ-014 o_macPos, o_macNeg, o_irSat  out  LANES each  per-lane sticky flags for the operation.

Function
REQ-015 Pipeline: S1 registers the products (2*MUL_W signed); S2 accumulates; S3 shifts, saturates and holds the result.
REQ-016 Latency: o_resValid rises 3 cycles after acceptance of the i_last term.
REQ-017 Terms are accepted back to back, one per cycle; there is no bubble between operations.
REQ-018 On the i_first term S2 computes acc = i_init + product; otherwise acc = acc + product.
REQ-019 After each add, an exact sum > 2^(ACC_W-1)-1 sets macPos and a sum < -2^(ACC_W-1) sets macNeg; acc stores the sum wrapped (sign-extended) to ACC_W bits.
REQ-020 Flags are cleared on the i_first term and are sticky until that operation's result is output.
REQ-021 S3: the value is acc >>> 12 (arithmetic) when sf=1, else acc; o_mac is its low 32 bits.
REQ-022 The IR value clamps to [lm ? 0 : -32768, 32767]; o_irSat sets when clamping alters the value.
REQ-023 The output holds stable while o_resValid=1 and i_resReady=0.
REQ-024 o_ready = !(o_resValid && !i_resReady) && !(S1 or S2 holding a stalled finished term); a stalled pipeline freezes all stages.
REQ-025 With o_resValid and i_resReady both high, a new result is loaded in the same cycle without a gap.
REQ-026 The i_last and i_first markers travel with their term through S1/S2; sf/lm travel with the operation.
REQ-027 i_first on a term while an operation is still open aborts the open operation silently: it produces no result and the new operation is seeded.

Reset
REQ-028 Asynchronous assertion of i_nRst clears all stage valids, accumulators and flags, and drives o_resValid=0, o_mac=0, o_ir=0 and all flags to 0.
REQ-029 o_ready is 1 after reset; reset mid-operation discards the operation with no partial result output.

Configuration
REQ-030 GTE_MAC_FLAGS_EN defined: flags behave as in REQ-019 to REQ-022.
REQ-031 GTE_MAC_FLAGS_EN undefined: o_macPos, o_macNeg and o_irSat are tied to 0 and the flag logic is removed; o_mac and o_ir are unchanged.

Structure
REQ-032 The shared package gte_mac_pkg holds the IR limits (32767, -32768), SF_SHIFT=12 and the per-lane flag struct typedef.
REQ-033 The per-lane datapath (product, accumulate, shift, saturate) is sub-module gte_mac_lane, instantiated LANES times by generate; gte_mac_pipe owns the handshake and stall control.

Verification
REQ-034 LANES=1: a=0x1000, b=0x1000, sf=1, first=last, init=0 -> after 3 cycles o_mac=0x1000, o_ir=0x1000, no flags.
REQ-035 Three terms a=b=0x7FFF, sf=0 -> o_mac=0xBFFD0003, o_ir=0x7FFF, irSat=1.
REQ-036 init=2^43-1, a=1, b=1 -> o_mac=low 32 bits of -2^43 (0x00000000), macPos=1; init=-2^43, a=-1, b=1 -> macNeg=1.
REQ-037 Single term a=-0x2000, b=0x1000, sf=1: with lm=1 -> o_ir=0, irSat=1; with lm=0 -> o_ir=-0x2000 (0xE000), irSat=0.
REQ-038 Hold i_resReady=0 for 10 cycles while streaming ops -> o_ready falls once the pipe is full, the held result is unchanged, and all results are delivered in order after release with none lost.
REQ-039 Assert i_nRst after the second of three terms -> outputs are 0 immediately; after release o_ready=1 and no stale result appears.
